// File: rtl/adder_tree_sequencer_if.sv
// Bundle of the adder_tree_sequencer job, chunk, tree and result signals.
// The slave modport is the sequencer's view. The master modport is the view of
// whatever drives jobs and chunks and closes the loop through the adder tree.
// Each chunk is a packed array of TREE_LENGTH lanes of DATA_WIDTH bits.
// Lane 0 sits in the lowest bits, and every lane is a signed two's-complement value.
interface adder_tree_sequencer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int TREE_LENGTH = 42,
  parameter int MAX_CHUNKS  = 16,
  parameter int ACC_WIDTH   = 16
);
  localparam int TREE_OUT_WIDTH = DATA_WIDTH + $clog2(TREE_LENGTH);
  localparam int CNT_W          = $clog2(MAX_CHUNKS + 1);

  // Job request
  logic                                     in_start;
  logic [CNT_W-1:0]                         in_num_chunks;
  logic                                     out_busy;

  // Chunk stream
  logic                                     in_chunk_valid;
  logic                                     out_chunk_ready;
  logic [TREE_LENGTH-1:0][DATA_WIDTH-1:0]   in_chunk_addends;

  // External combinational adder tree loop
  logic [TREE_LENGTH-1:0][DATA_WIDTH-1:0]   out_tree_addends;
  logic signed [TREE_OUT_WIDTH-1:0]         in_tree_sum;

  // Result handshake
  logic                                     out_result_valid;
  logic                                     in_result_ready;
  logic signed [ACC_WIDTH-1:0]              out_result;
  logic                                     out_overflow;

  modport slave (
    input  in_start, in_num_chunks, in_chunk_valid, in_chunk_addends,
           in_tree_sum, in_result_ready,
    output out_busy, out_chunk_ready, out_tree_addends, out_result_valid,
           out_result, out_overflow
  );

  modport master (
    output in_start, in_num_chunks, in_chunk_valid, in_chunk_addends,
           in_tree_sum, in_result_ready,
    input  out_busy, out_chunk_ready, out_tree_addends, out_result_valid,
           out_result, out_overflow
  );
endinterface

// File: rtl/adder_tree_sequencer.sv
// adder_tree_sequencer: feeds a job of up to MAX_CHUNKS chunks through an external
// combinational adder tree, one chunk per cycle. It accumulates the partial sums
// and returns the job total over a valid/ready handshake.
//
// Pipeline for each chunk:
//   - accept edge: the chunk is registered into out_tree_addends and stage_valid is set
//   - next edge:   the tree result is added into the accumulator
//   - next edge:   DRAIN sees an empty stage, latches the result and enters DONE
//
// Optional feature, selected by the macro ADDER_TREE_SEQUENCER_SATURATE_EN:
//   defined   -> the accumulator saturates, and out_overflow is a sticky clip flag
//   undefined -> the accumulator wraps, and out_overflow is tied to 0
module adder_tree_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int TREE_LENGTH = 42,
  parameter int MAX_CHUNKS  = 16,
  parameter int ACC_WIDTH   = 16
) (
  input  logic                  in_clk,
  input  logic                  in_reset_n,
  adder_tree_sequencer_if.slave bus
);
  localparam int TREE_OUT_WIDTH = DATA_WIDTH + $clog2(TREE_LENGTH);
  localparam int CNT_W          = $clog2(MAX_CHUNKS + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CHUNKS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  // The accumulator must be able to hold at least one tree result without loss.
  if (ACC_WIDTH < TREE_OUT_WIDTH) begin : g_cfg_check
    $error("adder_tree_sequencer: ACC_WIDTH must be >= DATA_WIDTH+$clog2(TREE_LENGTH)");
  end

  logic [1:0]                  state_q, state_d;
  logic [CNT_W-1:0]            remaining_q, remaining_d;
  logic                        stage_valid_q, stage_valid_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] result_q, result_d;

  logic                        start_accept;
  logic                        chunk_accept;
  logic [CNT_W-1:0]            num_clamped;
  logic signed [ACC_WIDTH-1:0] sum_next;

`ifdef ADDER_TREE_SEQUENCER_SATURATE_EN
  localparam int SUM_W = ACC_WIDTH + 1;
  logic                        overflow_q, overflow_d;
  logic signed [SUM_W-1:0]     sum_wide;
  logic                        sum_clip;
`endif

  // Handshake qualifiers. Ready is a pure function of state, so there is no path from valid to ready.
  always_comb begin
    start_accept = (state_q == ST_IDLE) && bus.in_start;
    chunk_accept = (state_q == ST_RUN) && bus.in_chunk_valid;
    num_clamped  = (bus.in_num_chunks > MAX_CNT) ? MAX_CNT : bus.in_num_chunks;
  end

`ifdef ADDER_TREE_SEQUENCER_SATURATE_EN
  // One guard bit detects a clip. On a clip the value pins to the rail that the true sum crossed.
  always_comb begin
    sum_wide = SUM_W'(acc_q) + SUM_W'(bus.in_tree_sum);
    sum_clip = sum_wide[SUM_W-1] ^ sum_wide[SUM_W-2];
    if (!sum_clip) begin
      sum_next = sum_wide[ACC_WIDTH-1:0];
    end else if (sum_wide[SUM_W-1]) begin
      sum_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end else begin
      sum_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  // Wrapping add. The tree sum is sign-extended to ACC_WIDTH, and the carry out of the top bit is dropped.
  always_comb begin
    sum_next = acc_q + ACC_WIDTH'(bus.in_tree_sum);
  end
`endif

  // Next-state logic for the control FSM, the chunk counter, the stage flag and the accumulator.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    stage_valid_d = chunk_accept;
    acc_d         = acc_q;
    result_d      = result_q;
`ifdef ADDER_TREE_SEQUENCER_SATURATE_EN
    overflow_d    = overflow_q;
`endif

    // Fold the previous chunk's tree result into the accumulator.
    // This runs in RUN and in DRAIN, whenever the stage holds a chunk.
    if (stage_valid_q) begin
      acc_d = sum_next;
`ifdef ADDER_TREE_SEQUENCER_SATURATE_EN
      if (sum_clip) begin
        overflow_d = 1'b1;
      end
`endif
    end

    if (chunk_accept) begin
      remaining_d = remaining_q - ONE_CNT;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_accept) begin
          acc_d = '0;
`ifdef ADDER_TREE_SEQUENCER_SATURATE_EN
          overflow_d = 1'b0;
`endif
          if (num_clamped == '0) begin
            // An empty job completes immediately with a zero result.
            state_d  = ST_DONE;
            result_d = '0;
          end else begin
            state_d     = ST_RUN;
            remaining_d = num_clamped;
          end
        end
      end
      ST_RUN: begin
        if (chunk_accept && (remaining_q == ONE_CNT)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The stage is empty once the final chunk's sum has been folded in.
        if (!stage_valid_q) begin
          state_d  = ST_DONE;
          result_d = acc_q;
        end
      end
      default: begin
        if (bus.in_result_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Control and datapath registers. Reset clears them immediately and discards any job in flight.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      stage_valid_q <= 1'b0;
      acc_q         <= '0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      stage_valid_q <= stage_valid_d;
      acc_q         <= acc_d;
      result_q      <= result_d;
    end
  end

`ifdef ADDER_TREE_SEQUENCER_SATURATE_EN
  // Sticky clip flag. Only a newly accepted job clears it.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.out_overflow = overflow_q;
`else
  assign bus.out_overflow = 1'b0;
`endif

  // Operand register for each lane of the tree. A lane loads only on a chunk accept and otherwise holds its value.
  for (genvar gi = 0; gi < TREE_LENGTH; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_q, lane_d;

    // Select the new chunk lane or keep the current operand.
    always_comb begin
      lane_d = chunk_accept ? bus.in_chunk_addends[gi] : lane_q;
    end

    // Lane operand flop.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
        lane_q <= '0;
      end else begin
        lane_q <= lane_d;
      end
    end

    assign bus.out_tree_addends[gi] = lane_q;
  end

  assign bus.out_chunk_ready  = (state_q == ST_RUN);
  assign bus.out_result_valid = (state_q == ST_DONE);
  assign bus.out_busy         = (state_q != ST_IDLE);
  assign bus.out_result       = result_q;

endmodule
